fir_xifu_regfile_sb: RTL and testbench

Parametrised FIR XIFU register file with an integrated per-register write scoreboard: configurable data width, register count and read-port count, a write-through bypass from the writeback port, and busy tracking keyed by X-interface instruction ID. It sits between the ID/EX stages, which issue destination registers and read operands, and the WB stage, which commits results. It also handles the XIF kill path. It replaces the plain register file so that EX can detect RAW/WAW hazards without external bookkeeping.

---
 rtl/fir_xifu_pkg.sv | 20 ++
 rtl/fir_xifu_sb_entry.sv | 79 +++++++
 rtl/fir_xifu_regfile_sb.sv | 120 ++++++++++++
 tb/tb_fir_xifu_regfile_sb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_xifu_pkg.sv
// ============================================================================
// Module : fir_xifu_pkg
// Brief  : Shared types and defaults for the FIR XIFU scoreboarded register file
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_xifu_pkg;

    localparam int C_ID_W = 4;

    // Scoreboard view of one register at the default ID width
    typedef struct packed {
        logic              busy;
        logic [C_ID_W-1:0] id;
    } fir_xifu_sb_entry_t;

endpackage : fir_xifu_pkg

`default_nettype wire

// File: rtl/fir_xifu_sb_entry.sv
// ============================================================================
// Module : fir_xifu_sb_entry
// Brief  : One register slot: data, busy flag and owning ID with write/kill logic
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_xifu_sb_entry
    import fir_xifu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ID_W   = C_ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_issue_set,
    input  logic [ID_W-1:0]   i_issue_id,
    input  logic              i_wb_we,
    input  logic [ID_W-1:0]   i_wb_id,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_kill_valid,
    input  logic [ID_W-1:0]   i_kill_id,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_busy_nxt,
    output logic              o_wb_match
);

    logic [DATA_W-1:0] r_data;
    logic              r_busy;
    logic [ID_W-1:0]   r_id;
    logic              w_busy_nxt;
    logic              w_wb_match;
    logic              w_kill_match;

    assign w_wb_match   = r_busy & (r_id == i_wb_id);
    assign w_kill_match = r_busy & i_kill_valid & (r_id == i_kill_id);

    // Issue only fires on an idle slot, so it never races a release here
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clear) begin
            w_busy_nxt = 1'b0;
        end else if (i_issue_set) begin
            w_busy_nxt = 1'b1;
        end else if ((i_wb_we && w_wb_match) || w_kill_match) begin
            w_busy_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_busy <= 1'b0;
            r_id   <= '0;
        end else if (i_clear) begin
            r_data <= '0;
            r_busy <= 1'b0;
            r_id   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (i_wb_we) begin
                r_data <= i_wb_data;
            end
            if (i_issue_set) begin
                r_id <= i_issue_id;
            end
        end
    end

    assign o_data     = r_data;
    assign o_busy     = r_busy;
    assign o_busy_nxt = w_busy_nxt;
    assign o_wb_match = w_wb_match;

endmodule : fir_xifu_sb_entry

`default_nettype wire

// File: rtl/fir_xifu_regfile_sb.sv
// ============================================================================
// Module : fir_xifu_regfile_sb
// Brief  : XIFU register file with write bypass and per-register ID scoreboard
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_xifu_regfile_sb
    import fir_xifu_pkg::*;
#(
    parameter int NB_REGS     = 4,
    parameter int DATA_W      = 32,
    parameter int NB_RD_PORTS = 3,
    parameter int ID_W        = C_ID_W,
    parameter int RA_W        = $clog2(NB_REGS),
    parameter int NB_W        = $clog2(NB_REGS + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    input  logic                                issue_valid_i,
    input  logic [RA_W-1:0]                     issue_rd_i,
    input  logic [ID_W-1:0]                     issue_id_i,
    output logic                                issue_ready_o,
    input  logic [NB_RD_PORTS-1:0][RA_W-1:0]    rd_addr_i,
    output logic [NB_RD_PORTS-1:0][DATA_W-1:0]  rd_data_o,
    output logic [NB_RD_PORTS-1:0]              rd_busy_o,
    input  logic                                wb_valid_i,
    input  logic [RA_W-1:0]                     wb_rd_i,
    input  logic [ID_W-1:0]                     wb_id_i,
    input  logic [DATA_W-1:0]                   wb_data_i,
    input  logic                                kill_valid_i,
    input  logic [ID_W-1:0]                     kill_id_i,
    output logic [NB_REGS-1:0]                  busy_o,
    output logic [NB_W-1:0]                     nb_busy_o,
    output logic                                wb_err_o
);

    localparam int C_SLOTS = 2 ** RA_W;

    logic [DATA_W-1:0]  w_data [C_SLOTS];
    logic [C_SLOTS-1:0] w_busy;
    logic [C_SLOTS-1:0] w_busy_nxt;
    logic [C_SLOTS-1:0] w_wb_match;
    logic               w_issue_fire;
    logic [NB_W-1:0]    w_pop_nxt;
    logic [NB_W-1:0]    r_nb_busy;
    logic               r_wb_err;

    assign issue_ready_o = ~w_busy[issue_rd_i];
    assign w_issue_fire  = issue_valid_i & ~w_busy[issue_rd_i];

    for (genvar g = 0; g < NB_REGS; g++) begin : g_entry
        fir_xifu_sb_entry #(
            .DATA_W (DATA_W),
            .ID_W   (ID_W)
        ) u_entry (
            .clk          (clk_i),
            .rst          (rst_i),
            .i_clear      (clear_i),
            .i_issue_set  (w_issue_fire && (issue_rd_i == RA_W'(g))),
            .i_issue_id   (issue_id_i),
            .i_wb_we      (wb_valid_i && (wb_rd_i == RA_W'(g))),
            .i_wb_id      (wb_id_i),
            .i_wb_data    (wb_data_i),
            .i_kill_valid (kill_valid_i),
            .i_kill_id    (kill_id_i),
            .o_data       (w_data[g]),
            .o_busy       (w_busy[g]),
            .o_busy_nxt   (w_busy_nxt[g]),
            .o_wb_match   (w_wb_match[g])
        );
    end : g_entry

    // Unpopulated address slots read as an idle zero register
    if (NB_REGS < C_SLOTS) begin : g_pad
        for (genvar g = NB_REGS; g < C_SLOTS; g++) begin : g_slot
            assign w_data[g]     = '0;
            assign w_busy[g]     = 1'b0;
            assign w_busy_nxt[g] = 1'b0;
            assign w_wb_match[g] = 1'b0;
        end : g_slot
    end : g_pad

    for (genvar p = 0; p < NB_RD_PORTS; p++) begin : g_rd_port
        logic w_hit;
        assign w_hit        = wb_valid_i && (wb_rd_i == rd_addr_i[p]);
        assign rd_data_o[p] = w_hit ? wb_data_i : w_data[rd_addr_i[p]];
        assign rd_busy_o[p] = w_busy[rd_addr_i[p]] & ~(w_hit & w_wb_match[rd_addr_i[p]]);
    end : g_rd_port

    always_comb begin
        w_pop_nxt = '0;
        for (int i = 0; i < NB_REGS; i++) begin
            w_pop_nxt = w_pop_nxt + NB_W'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_nb_busy <= '0;
            r_wb_err  <= 1'b0;
        end else if (clear_i) begin
            r_nb_busy <= '0;
            r_wb_err  <= 1'b0;
        end else begin
            r_nb_busy <= w_pop_nxt;
            if (wb_valid_i && !w_wb_match[wb_rd_i]) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign busy_o    = w_busy[NB_REGS-1:0];
    assign nb_busy_o = r_nb_busy;
    assign wb_err_o  = r_wb_err;

endmodule : fir_xifu_regfile_sb

`default_nettype wire

// File: tb/tb_fir_xifu_regfile_sb.sv
// ============================================================================
// Module : tb_fir_xifu_regfile_sb
// Brief  : Directed self-checking bench for the scoreboarded XIFU register file
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_xifu_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: 4 x 32, 3 read ports
    logic            issue_valid = 1'b0;
    logic [1:0]      issue_rd    = '0;
    logic [3:0]      issue_id    = '0;
    logic            issue_ready;
    logic [2:0][1:0] rd_addr     = '0;
    logic [2:0][31:0] rd_data;
    logic [2:0]      rd_busy;
    logic            wb_valid    = 1'b0;
    logic [1:0]      wb_rd       = '0;
    logic [3:0]      wb_id       = '0;
    logic [31:0]     wb_data     = '0;
    logic            kill_valid  = 1'b0;
    logic [3:0]      kill_id     = '0;
    logic [3:0]      busy;
    logic [2:0]      nb_busy;
    logic            wb_err;

    // Wide configuration: 8 x 16
    logic            issue_valid8 = 1'b0;
    logic [2:0]      issue_rd8    = '0;
    logic [3:0]      issue_id8    = '0;
    logic            issue_ready8;
    logic [2:0][2:0] rd_addr8     = '0;
    logic [2:0][15:0] rd_data8;
    logic [2:0]      rd_busy8;
    logic [7:0]      busy8;
    logic [3:0]      nb_busy8;
    logic            wb_err8;

    int n_tests = 0;
    int n_fail  = 0;

    fir_xifu_regfile_sb dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_id_i    (issue_id),
        .issue_ready_o (issue_ready),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_busy_o     (rd_busy),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .wb_id_i       (wb_id),
        .wb_data_i     (wb_data),
        .kill_valid_i  (kill_valid),
        .kill_id_i     (kill_id),
        .busy_o        (busy),
        .nb_busy_o     (nb_busy),
        .wb_err_o      (wb_err)
    );

    fir_xifu_regfile_sb #(.NB_REGS(8), .DATA_W(16)) dut8 (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .issue_valid_i (issue_valid8),
        .issue_rd_i    (issue_rd8),
        .issue_id_i    (issue_id8),
        .issue_ready_o (issue_ready8),
        .rd_addr_i     (rd_addr8),
        .rd_data_o     (rd_data8),
        .rd_busy_o     (rd_busy8),
        .wb_valid_i    (1'b0),
        .wb_rd_i       (3'd0),
        .wb_id_i       (4'd0),
        .wb_data_i     (16'd0),
        .kill_valid_i  (1'b0),
        .kill_id_i     (4'd0),
        .busy_o        (busy8),
        .nb_busy_o     (nb_busy8),
        .wb_err_o      (wb_err8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rd_addr = {2'd3, 2'd1, 2'd0};
        issue_valid = 1'b1; issue_rd = 2'd2; issue_id = 4'd5;
        #1;
        check("rst_rd_data0", rd_data[0], 0);
        check("rst_rd_data1", rd_data[1], 0);
        check("rst_rd_data2", rd_data[2], 0);
        check("rst_rd_busy",  rd_busy, 0);
        check("rst_busy",     busy, 0);
        check("rst_nb_busy",  nb_busy, 0);
        check("rst_wb_err",   wb_err, 0);
        check("rst_ready",    issue_ready, 1);

        // ---------------- issue r2 id5, then bypassed writeback ----------------
        tick();
        issue_valid = 1'b0;
        rd_addr = {2'd0, 2'd1, 2'd2};
        #1;
        check("iss_rd_busy",  rd_busy[0], 1);
        check("iss_busy",     busy, 4'b0100);
        check("iss_nb_busy",  nb_busy, 1);
        wb_valid = 1'b1; wb_rd = 2'd2; wb_id = 4'd5; wb_data = 32'hCAFE0001;
        #1;
        check("byp_rd_data",  rd_data[0], 32'hCAFE0001);
        check("byp_rd_busy",  rd_busy[0], 0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("wb_busy_clr",  busy, 0);
        check("wb_nb_busy",   nb_busy, 0);
        check("wb_no_err",    wb_err, 0);
        check("wb_stored",    rd_data[0], 32'hCAFE0001);

        // ---------------- WAW stall on r1 ----------------
        issue_valid = 1'b1; issue_rd = 2'd1; issue_id = 4'd3;
        tick();
        issue_id = 4'd4;
        #1;
        check("waw_stall",    issue_ready, 0);
        tick();
        check("waw_busy",     busy, 4'b0010);
        wb_valid = 1'b1; wb_rd = 2'd1; wb_id = 4'd3; wb_data = 32'h0000_0011;
        #1;
        check("waw_stall_wb", issue_ready, 0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("reissue_rdy",  issue_ready, 1);
        tick();
        issue_valid = 1'b0;
        #1;
        check("reissue_busy", busy, 4'b0010);
        check("reissue_nb",   nb_busy, 1);
        wb_valid = 1'b1; wb_rd = 2'd1; wb_id = 4'd4; wb_data = 32'h0000_0022;
        tick();
        wb_valid = 1'b0;
        #1;
        check("reissue_done", busy, 0);
        check("reissue_err",  wb_err, 0);

        // ---------------- kill: preload r0/r3, claim both with id7, kill ----------------
        issue_valid = 1'b1; issue_rd = 2'd0; issue_id = 4'd1;
        tick();
        issue_rd = 2'd3; issue_id = 4'd2;
        wb_valid = 1'b1; wb_rd = 2'd0; wb_id = 4'd1; wb_data = 32'hA000_0000;
        tick();
        issue_valid = 1'b0;
        wb_rd = 2'd3; wb_id = 4'd2; wb_data = 32'hA000_0003;
        tick();
        wb_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 2'd0; issue_id = 4'd7;
        tick();
        issue_rd = 2'd3;
        tick();
        issue_valid = 1'b0;
        #1;
        check("kill_pre_busy", busy, 4'b1001);
        check("kill_pre_nb",   nb_busy, 2);
        kill_valid = 1'b1; kill_id = 4'd6;
        tick();
        check("kill_miss",     busy, 4'b1001);
        kill_id = 4'd7;
        tick();
        kill_valid = 1'b0;
        rd_addr = {2'd2, 2'd3, 2'd0};
        #1;
        check("kill_busy",     busy, 0);
        check("kill_nb",       nb_busy, 0);
        check("kill_r0_data",  rd_data[0], 32'hA000_0000);
        check("kill_r3_data",  rd_data[1], 32'hA000_0003);

        // kill and WB hitting the same entry in one cycle
        issue_valid = 1'b1; issue_rd = 2'd2; issue_id = 4'd6;
        tick();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 2'd2; wb_id = 4'd6; wb_data = 32'h0000_0066;
        kill_valid = 1'b1; kill_id = 4'd6;
        tick();
        wb_valid = 1'b0; kill_valid = 1'b0;
        #1;
        check("killwb_busy",   busy, 0);
        check("killwb_err",    wb_err, 0);
        check("killwb_data",   rd_data[2], 32'h0000_0066);

        // ---------------- unclaimed writeback -> sticky error, then clear ----------------
        wb_valid = 1'b1; wb_rd = 2'd1; wb_id = 4'd9; wb_data = 32'h0000_0099;
        tick();
        wb_valid = 1'b0;
        rd_addr = {2'd2, 2'd1, 2'd3};
        #1;
        check("err_set",       wb_err, 1);
        check("err_data",      rd_data[1], 32'h0000_0099);
        check("err_busy",      busy, 0);
        tick();
        check("err_sticky",    wb_err, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        check("clr_err",       wb_err, 0);
        check("clr_busy",      busy, 0);
        check("clr_data0",     rd_data[0], 0);
        check("clr_data1",     rd_data[1], 0);
        check("clr_data2",     rd_data[2], 0);

        // ---------------- 8-register config: fill all claims, async reset ----------------
        for (int i = 0; i < 8; i++) begin
            issue_valid8 = 1'b1; issue_rd8 = 3'(i); issue_id8 = 4'(i + 1);
            tick();
        end
        issue_valid8 = 1'b0;
        rd_addr8 = {3'd7, 3'd4, 3'd0};
        #1;
        check("w8_nb_full",    nb_busy8, 8);
        check("w8_busy_full",  busy8, 8'hFF);
        check("w8_rd_busy",    rd_busy8, 3'b111);
        check("w8_ready",      issue_ready8, 0);
        issue_valid = 1'b1; issue_rd = 2'd1; issue_id = 4'd2;
        tick();
        issue_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_busy8",    busy8, 0);
        check("arst_nb8",      nb_busy8, 0);
        check("arst_rdbusy8",  rd_busy8, 0);
        check("arst_busy",     busy, 0);
        tick();
        rst = 1'b0;
        #1;
        check("arst_ready8",   issue_ready8, 1);
        check("arst_data8",    rd_data8[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule : tb_fir_xifu_regfile_sb

`default_nettype wire
